// File: rtl/my_main_pkg.sv
// Shared definitions for the min/max averaging block: default sizes,
// FSM state encoding and the frame-counter width.
package my_main_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int N_BYTES_DEF = 8;
    localparam int CNT_W_DEF   = $clog2(N_BYTES_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter must be able to hold N_BYTES itself, hence the extra bit.
    function automatic int cnt_width(input int n_bytes);
        return $clog2(n_bytes) + 1;
    endfunction

endpackage

// File: rtl/my_main_min_max_cell.sv
// Running minimum/maximum registers for one frame; exposes the post-update
// values so the parent can average them on the same edge as the last sample.
module min_max_cell
    import my_main_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init,
    input  logic              update,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] min_nxt,
    output logic [DATA_W-1:0] max_nxt
);

    logic [DATA_W-1:0] min_r;
    logic [DATA_W-1:0] max_r;

    // Next min/max: seed from the first sample, strict compares keep ties unchanged.
    always_comb begin
        min_nxt = min_r;
        max_nxt = max_r;
        if (init) begin
            min_nxt = data;
            max_nxt = data;
        end else if (update) begin
            if (data < min_r) begin
                min_nxt = data;
            end else begin
                min_nxt = min_r;
            end
            if (data > max_r) begin
                max_nxt = data;
            end else begin
                max_nxt = max_r;
            end
        end else begin
            min_nxt = min_r;
            max_nxt = max_r;
        end
    end

    // Min/max storage with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            min_r <= {DATA_W{1'b0}};
            max_r <= {DATA_W{1'b0}};
        end else begin
            min_r <= min_nxt;
            max_r <= max_nxt;
        end
    end

endmodule

// File: rtl/my_main.sv
// Frame averager: collects N_BYTES consecutive samples after start and
// outputs floor((min+max)/2) with a one-cycle done pulse.
module my_main
    import my_main_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int N_BYTES = N_BYTES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] W,
    output logic              done
);

    localparam int CNT_W = cnt_width(N_BYTES);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               init_s;
    logic               update_s;
    logic               last_s;
    logic [DATA_W-1:0]  min_nxt_s;
    logic [DATA_W-1:0]  max_nxt_s;
    logic [DATA_W:0]    sum_s;
    logic [DATA_W-1:0]  w_r;
    logic [DATA_W-1:0]  w_nxt_s;
    logic               done_r;

    min_max_cell #(
        .DATA_W (DATA_W)
    ) u_min_max (
        .clock   (clock),
        .reset   (reset),
        .init    (init_s),
        .update  (update_s),
        .data    (data),
        .min_nxt (min_nxt_s),
        .max_nxt (max_nxt_s)
    );

    assign last_s = (state_r == LOAD) && (count_r == CNT_W'(N_BYTES - 1));
    assign sum_s  = {1'b0, min_nxt_s} + {1'b0, max_nxt_s};

    // Next-state, counter and cell control; FINISH accepts start exactly like IDLE.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        init_s      = 1'b0;
        update_s    = 1'b0;
        case (state_r)
            IDLE, FINISH: begin
                if (start) begin
                    init_s      = 1'b1;
                    count_nxt_s = CNT_W'(1);
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                update_s    = 1'b1;
                count_nxt_s = count_r + CNT_W'(1);
                if (last_s) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Result latches only on the edge that takes the final sample.
    always_comb begin
        w_nxt_s = w_r;
        if (state_nxt_s == FINISH) begin
            w_nxt_s = sum_s[DATA_W:1];
        end else begin
            w_nxt_s = w_r;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= {CNT_W{1'b0}};
            w_r     <= {DATA_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            w_r     <= w_nxt_s;
            done_r  <= (state_nxt_s == FINISH);
        end
    end

    assign W    = w_r;
    assign done = done_r;

endmodule

// File: tb/tb_my_main.sv
// Directed self-checking bench for my_main (DATA_W=8, N_BYTES=8).
module tb_my_main;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic [7:0] W;
    logic       done;

    int checks;
    int errors;

    my_main #(
        .DATA_W  (8),
        .N_BYTES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .data  (data),
        .W     (W),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string name, input logic [7:0] exp_w, input logic exp_done);
        checks++;
        if (W !== exp_w) begin
            errors++;
            $display("FAIL %s: W=%0d expected %0d", name, W, exp_w);
        end
        checks++;
        if (done !== exp_done) begin
            errors++;
            $display("FAIL %s: done=%0b expected %0b", name, done, exp_done);
        end
    endtask

    // Feeds 8 samples (sample 1 in frame[7:0]); returns #1 into the FINISH cycle.
    task automatic feed(input logic [63:0] frame, input bit hold, input logic [7:0] exp_w, input string name);
        for (int i = 0; i < 8; i++) begin
            start = (i == 0) || hold;
            data  = frame[8*i +: 8];
            step();
            if (i < 7) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_busy: done=%0b expected 0 after sample %0d", name, done, i + 1);
                end
            end
        end
        check_out(name, exp_w, 1'b1);
    endtask

    task automatic after_finish(input string name, input logic [7:0] exp_w);
        start = 1'b0;
        data  = 8'd0;
        step();
        check_out(name, exp_w, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        data  = 8'hFF;
        step();
        step();
        check_out("reset", 8'd0, 1'b0);
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 20; i++) begin
            data = 8'(i * 13);
            step();
            check_out("idle_hold", 8'd0, 1'b0);
        end
    endtask

    task automatic test_basic();
        feed({8'd72, 8'd112, 8'd241, 8'd41, 8'd38, 8'd218, 8'd76, 8'd15}, 1'b0, 8'd128, "basic");
        after_finish("basic_hold", 8'd128);
        step();
        check_out("basic_hold2", 8'd128, 1'b0);
        // Ties at both ends: min 9, max 200 -> 104.
        feed({8'd9, 8'd200, 8'd9, 8'd200, 8'd9, 8'd200, 8'd9, 8'd9}, 1'b0, 8'd104, "ties");
        after_finish("ties_hold", 8'd104);
    endtask

    task automatic test_const();
        feed({8{8'h55}}, 1'b0, 8'd85, "const55");
        after_finish("const55_hold", 8'd85);
    endtask

    task automatic test_alternating();
        feed({8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0}, 1'b0, 8'd127, "alternating");
        after_finish("alternating_hold", 8'd127);
    endtask

    task automatic test_back_to_back();
        // start held through LOAD and into FINISH: second frame begins at the FINISH edge.
        feed({8'd100, 8'd60, 8'd50, 8'd90, 8'd80, 8'd70, 8'd40, 8'd20}, 1'b1, 8'd60, "b2b_first");
        feed({8'd33, 8'd1, 8'd77, 8'd12, 8'd200, 8'd5, 8'd150, 8'd90}, 1'b0, 8'd100, "b2b_second");
        after_finish("b2b_hold", 8'd100);
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            data  = 8'd250 - 8'(i);
            step();
        end
        reset = 1'b1;
        start = 1'b0;
        step();
        reset = 1'b0;
        check_out("abort_reset", 8'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            data = 8'd250;
            step();
            check_out("abort_no_done", 8'd0, 1'b0);
        end
        feed({8{8'd10}}, 1'b0, 8'd10, "after_abort");
        after_finish("after_abort_hold", 8'd10);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        data   = 8'd0;
        #1;
        test_reset();
        test_idle_hold();
        test_basic();
        test_const();
        test_alternating();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/my_main.md
MY_MAIN -- requirements
Module: my_main

Interface
REQ-001 Parameter DATA_W, default 8, width of each input sample and of the result W.
REQ-002 Parameter N_BYTES, default 8, samples per frame; power of two, at least 2.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  frame start request; level sampled at the clock edge.
REQ-007 data  input  DATA_W  unsigned sample stream, one sample per clock.
REQ-008 W  output  DATA_W  average of the smallest and largest sample of the last frame.
REQ-009 done  output  1  one-cycle pulse marking W as newly valid.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, LOAD, FINISH.
REQ-011 In IDLE with start=1 at an edge, the block SHALL take data as sample 1, set min=max=data and count=1, then enter LOAD.
REQ-012 In LOAD, each edge SHALL take data as the next sample, update min/max with unsigned compare, and increment count.
REQ-013 LOAD SHALL exit to FINISH on the edge that takes sample N_BYTES (count reaching N_BYTES).
REQ-014 Samples SHALL be taken on N_BYTES consecutive edges, with no gaps or data-valid signal.
REQ-015 On entry to FINISH, W SHALL be floor((min+max)/2), computed on a DATA_W+1-bit sum with no overflow.
REQ-016 done SHALL be 1 for exactly the FINISH cycle, which is the cycle after the last sample edge; latency from the start edge is N_BYTES edges.
REQ-017 W SHALL hold its value until the next FINISH entry or reset.
REQ-018 FINISH SHALL return to IDLE after one cycle.
REQ-019 If start=1 during FINISH, that edge SHALL be accepted as sample 1 of a new frame, identical to IDLE, so frames run back-to-back.
REQ-020 start SHALL be ignored while in LOAD; the current frame is not restarted.
REQ-021 Ties (equal samples) SHALL leave min/max unchanged; the result is the same either way.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, W=0, done=0, min=0, max=0, count=0.
REQ-024 Reset SHALL override start and any in-progress frame; an aborted frame SHALL produce no done pulse.
REQ-025 After reset deasserts, the first edge with start=1 SHALL begin a new frame.

Structure
REQ-026 A shared package SHALL hold DATA_W and N_BYTES defaults, the state enumeration, and the count width constant clog2(N_BYTES)+1.
REQ-027 One sub-module, min_max_cell, SHALL hold the running min/max registers and their compare/update logic.
REQ-028 my_main SHALL hold the FSM, the counter and the averaging register.

Verification
REQ-029 Frame 15,76,218,38,41,241,112,72 with start on sample 1 -> 8 edges later W=128 and done=1 for one cycle.
REQ-030 All samples 0x55 -> W=85.
REQ-031 Samples 0,255,0,255,... -> W=127, confirming floor rounding and no 8-bit overflow.
REQ-032 Reset after sample 4, then a new frame of all 10 -> no done for the aborted frame; W=10 for the new frame.
REQ-033 start held high throughout LOAD, then a second frame starting in the FINISH cycle -> first W correct; second frame result appears 8 edges after FINISH with a correct W.
REQ-034 After reset with no start -> W=0, done=0 indefinitely.
